vga_fb_arbiter: RTL and testbench

// Shares one single-port framebuffer SRAM between the CPU (APB slave) and the VGA

---
 rtl/vga_fb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer SRAM shared by APB CPU access and VGA scanout prefetch
//
// Ports:
//   clock, reset_n            single clock, asynchronous active-low reset
//   in_p*                     APB slave (word index = in_paddr[ADDR_W+1:2]); in_prdata is registered
//   mem_*                     SRAM macro port, at most one access per cycle; read data arrives one cycle later
//   fb_en, frame_start        scanout enable and start-of-frame pulse (flush, restart at word 0)
//   pix_pop, pix_data,        pixel FIFO pop side towards vga_ctrl; pix_data reads 0 while empty
//   pix_empty, underflow      underflow is sticky until the next frame_start
module vga_fb_arbiter #(
    parameter int FB_WORDS   = 327680,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic              in_pwrite,
    input  logic [31:0]       in_pwdata,
    input  logic [3:0]        in_pstrb,
    output logic              in_pready,
    output logic [31:0]       in_prdata,
    output logic              in_pslverr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    input  logic              fb_en,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [31:0]       pix_data,
    output logic              pix_empty,
    output logic              underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [31:0]       FB_WORDS_C = 32'(FB_WORDS);
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(FB_WORDS - 1);
    localparam logic [LVL_W:0]    DEPTH_C    = (LVL_W + 1)'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LOW_C      = LVL_W'(LOW_WATER);

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RDAT, C_RESP} cpu_state_t;

    cpu_state_t        c_state;
    logic [ADDR_W-1:0] cpu_word;
    logic              cpu_in_range;
    logic              cpu_want;
    logic              cpu_grant;

    logic [ADDR_W-1:0] fetch_addr;
    logic              inflight;
    logic [LVL_W-1:0]  level;
    logic [LVL_W:0]    occupancy;
    logic              scan_want;
    logic              scan_grant;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop_ok;

    logic              unused_paddr_bits;
    assign unused_paddr_bits = ^{in_paddr[31:ADDR_W+2], in_paddr[1:0]};

    assign cpu_word     = in_paddr[ADDR_W+1:2];
    assign cpu_in_range = 32'(cpu_word) < FB_WORDS_C;
    assign cpu_want     = (c_state == C_WAIT) && cpu_in_range;

    // A read in flight already owns a FIFO slot, so counting it here is what
    // guarantees a push never lands on a full FIFO.
    assign occupancy  = {1'b0, level} + (LVL_W + 1)'(inflight);
    assign scan_want  = fb_en && !frame_start && (occupancy < DEPTH_C);

    // Scanout only yields to the CPU once the FIFO has a comfortable margin.
    assign scan_grant = scan_want && (!cpu_want || (level < LOW_C));
    assign cpu_grant  = cpu_want && !scan_grant;

    assign mem_en    = scan_grant || cpu_grant;
    assign mem_we    = cpu_grant && in_pwrite;
    assign mem_addr  = scan_grant ? fetch_addr : cpu_word;
    assign mem_wdata = in_pwdata;
    assign mem_wmask = in_pstrb;

    // Data returning for a read issued before frame_start belongs to the old
    // frame and is discarded.
    assign push   = inflight && !frame_start;
    assign pop_ok = pix_pop && (level != '0) && !frame_start;

    assign pix_empty = (level == '0);
    assign pix_data  = pix_empty ? 32'h0 : fifo_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fetch_addr <= '0;
            inflight   <= 1'b0;
            underflow  <= 1'b0;
        end else if (frame_start) begin
            level      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fetch_addr <= '0;
            inflight   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop_ok) begin
                level <= level + 1'b1;
            end else if (!push && pop_ok) begin
                level <= level - 1'b1;
            end
            if (pix_pop && (level == '0)) begin
                underflow <= 1'b1;
            end
            inflight <= scan_grant;
            if (scan_grant) begin
                fetch_addr <= (fetch_addr == LAST_WORD) ? '0 : fetch_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_state    <= C_IDLE;
            in_pready  <= 1'b0;
            in_pslverr <= 1'b0;
            in_prdata  <= 32'h0;
        end else begin
            case (c_state)
                C_IDLE: begin
                    in_pready  <= 1'b0;
                    in_pslverr <= 1'b0;
                    if (in_psel && in_penable && !in_pready) begin
                        c_state <= C_WAIT;
                    end
                end
                C_WAIT: begin
                    if (!cpu_in_range) begin
                        in_prdata  <= 32'h0;
                        in_pslverr <= 1'b1;
                        in_pready  <= 1'b1;
                        c_state    <= C_RESP;
                    end else if (cpu_grant) begin
                        if (in_pwrite) begin
                            in_pready <= 1'b1;
                            c_state   <= C_RESP;
                        end else begin
                            c_state <= C_RDAT;
                        end
                    end
                end
                C_RDAT: begin
                    in_prdata <= mem_rdata;
                    in_pready <= 1'b1;
                    c_state   <= C_RESP;
                end
                C_RESP: begin
                    in_pready  <= 1'b0;
                    in_pslverr <= 1'b0;
                    c_state    <= C_IDLE;
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter with SRAM model and reference memory
module tb_vga_fb_arbiter;

    localparam int FBW = 40;
    localparam int AW  = 19;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [31:0]   in_paddr;
    logic          in_psel;
    logic          in_penable;
    logic          in_pwrite;
    logic [31:0]   in_pwdata;
    logic [3:0]    in_pstrb;
    logic          in_pready;
    logic [31:0]   in_prdata;
    logic          in_pslverr;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_rdata;
    logic          fb_en;
    logic          frame_start;
    logic          pix_pop;
    logic [31:0]   pix_data;
    logic          pix_empty;
    logic          underflow;

    always #5 clock = ~clock;

    vga_fb_arbiter #(
        .FB_WORDS(FBW), .ADDR_W(AW), .FIFO_DEPTH(16), .LOW_WATER(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
        .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .fb_en(fb_en), .frame_start(frame_start), .pix_pop(pix_pop),
        .pix_data(pix_data), .pix_empty(pix_empty), .underflow(underflow)
    );

    // SRAM macro model: read data valid exactly one cycle after issue, noise otherwise.
    logic [31:0] sram [0:63];
    logic        preload;
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) sram[i] <= 32'(i);
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) sram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr[5:0]];
        else                   mem_rdata <= $urandom;
    end

    int          n_mem = 0;
    int          n_wr  = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wmask = '0;
    always @(negedge clock) begin
        if (reset_n && mem_en) begin
            n_mem++;
            if (mem_we) begin
                n_wr++;
                last_waddr = 32'(mem_addr);
                last_wdata = mem_wdata;
                last_wmask = mem_wmask;
            end
        end
    end

    logic [31:0] ref_mem [0:FBW-1];
    int n_vec = 0;
    int n_err = 0;
    int kk    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic err,
                       output int lat, output int nm);
        int m0;
        in_paddr = addr; in_pwrite = wr; in_pwdata = wd; in_pstrb = st;
        in_psel = 1'b1; in_penable = 1'b0;
        tick();
        in_penable = 1'b1;
        m0  = n_mem;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!in_pready && lat < 60);
        chk("apb_done", 32'(in_pready), 1);
        rd  = in_prdata;
        err = in_pslverr;
        nm  = n_mem - m0;
        tick();
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    task automatic pop1(input string tag);
        pix_pop = 1'b1;
        @(negedge clock);
        chk({tag, "_nonempty"}, 32'(pix_empty), 0);
        chk({tag, "_data"}, pix_data, ref_mem[kk % FBW]);
        @(posedge clock);
        #1;
        pix_pop = 1'b0;
        kk++;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        kk = 0;
    endtask

    task automatic fill_then_hold();
        fb_en = 1'b1;
        repeat (40) tick();
        fb_en = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        err;
        int          lat, nm, w0, op, idx;

        reset_n = 1'b0; preload = 1'b1;
        in_paddr = '0; in_psel = 0; in_penable = 0; in_pwrite = 0; in_pwdata = '0; in_pstrb = '0;
        fb_en = 0; frame_start = 0; pix_pop = 0;
        for (int i = 0; i < FBW; i++) ref_mem[i] = 32'(i);
        repeat (3) tick();
        chk("rst_pready", 32'(in_pready), 0);
        chk("rst_pslverr", 32'(in_pslverr), 0);
        chk("rst_prdata", in_prdata, 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_pix_empty", 32'(pix_empty), 1);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_underflow", 32'(underflow), 0);
        preload = 1'b0; reset_n = 1'b1;
        tick();

        // Masked write then read-back, latency 2 / 3 after the access phase.
        apb(1'b1, 32'd5 << 2, 32'h00AABBCC, 4'b0111, rd, err, lat, nm);
        ref_mem[5] = merge(ref_mem[5], 32'h00AABBCC, 4'b0111);
        chk("wr_latency", 32'(lat), 2);
        chk("wr_addr", last_waddr, 5);
        chk("wr_mask", 32'(last_wmask), 32'b0111);
        chk("wr_data", last_wdata, 32'h00AABBCC);
        chk("wr_err", 32'(err), 0);
        apb(1'b0, 32'd5 << 2, 32'h0, 4'h0, rd, err, lat, nm);
        chk("rd_latency", 32'(lat), 3);
        chk("rd_data", rd, ref_mem[5]);

        // Out-of-range word index.
        apb(1'b0, 32'(FBW) << 2, 32'h0, 4'h0, rd, err, lat, nm);
        chk("oor_err", 32'(err), 1);
        chk("oor_prdata", rd, 0);
        chk("oor_no_mem", 32'(nm), 0);
        chk("oor_err_drop", 32'(in_pslverr), 0);

        // Fill to exactly 16 with no pops, then drain.
        frame();
        fill_then_hold();
        chk("fill_nonempty", 32'(pix_empty), 0);
        chk("fill_head", pix_data, ref_mem[0]);
        for (int i = 0; i < 16; i++) pop1("drain");
        chk("drain_empty", 32'(pix_empty), 1);
        chk("drain_empty_data", pix_data, 0);

        // Pop on empty sets sticky underflow.
        pix_pop = 1'b1; tick(); pix_pop = 1'b0;
        chk("underflow_set", 32'(underflow), 1);
        repeat (4) tick();
        chk("underflow_sticky", 32'(underflow), 1);

        // Streaming: pop every 2 cycles, wrapping past the last framebuffer word.
        frame();
        chk("frame_clears_uf", 32'(underflow), 0);
        fb_en = 1'b1;
        repeat (40) tick();
        for (int i = 0; i < 50; i++) begin
            pop1("stream");
            tick();
        end

        // Level 2 with continuous pops: scanout keeps the FIFO below low water and starves the CPU.
        frame();
        fill_then_hold();
        for (int i = 0; i < 14; i++) pop1("lvl2_setup");
        in_paddr = 32'd7 << 2; in_pwrite = 1'b1; in_pwdata = ref_mem[7]; in_pstrb = 4'hF;
        in_psel = 1'b1; in_penable = 1'b0; fb_en = 1'b1; pix_pop = 1'b1;
        w0 = n_wr;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("starve_nonempty", 32'(pix_empty), 0);
            chk("starve_data", pix_data, ref_mem[kk % FBW]);
            chk("starve_mem_en", 32'(mem_en), 1);
            chk("starve_is_read", 32'(mem_we), 0);
            @(posedge clock);
            #1;
            kk++;
            if (c == 0) in_penable = 1'b1;
        end
        pix_pop = 1'b0;
        chk("starve_no_write", 32'(n_wr - w0), 0);
        lat = 0;
        while (!in_pready && lat < 60) begin
            tick();
            lat++;
        end
        chk("starve_release", 32'(in_pready), 1);
        chk("starve_wr_addr", last_waddr, 7);
        tick();
        in_psel = 1'b0; in_penable = 1'b0;

        // Level 8: CPU wins the contended cycle, minimum latency.
        frame();
        fill_then_hold();
        for (int i = 0; i < 8; i++) pop1("lvl8_setup");
        fb_en = 1'b1;
        apb(1'b1, 32'd3 << 2, ref_mem[3], 4'hF, rd, err, lat, nm);
        chk("lvl8_cpu_latency", 32'(lat), 2);
        chk("lvl8_wr_addr", last_waddr, 3);

        // frame_start with a read in flight at level 10.
        fb_en = 1'b0;
        frame();
        pix_pop = 1'b1; tick(); pix_pop = 1'b0;
        chk("fs_uf_before", 32'(underflow), 1);
        fill_then_hold();
        for (int i = 0; i < 6; i++) pop1("lvl10_setup");
        fb_en = 1'b1;
        @(negedge clock);
        chk("fs_inflight_issue", 32'(mem_en), 1);
        chk("fs_inflight_addr", 32'(mem_addr), 16);
        @(posedge clock);
        #1;
        frame();
        @(negedge clock);
        chk("fs_empty", 32'(pix_empty), 1);
        chk("fs_uf_clear", 32'(underflow), 0);
        chk("fs_next_addr", 32'(mem_addr), 0);
        @(posedge clock);
        #1;
        repeat (20) tick();
        for (int i = 0; i < 4; i++) pop1("fs_after");
        fb_en = 1'b0;
        repeat (3) tick();

        // Random CPU traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                idx = $urandom_range(0, FBW - 1);
                wd  = $urandom;
                st  = 4'($urandom);
                apb(1'b1, 32'(idx) << 2, wd, st, rd, err, lat, nm);
                ref_mem[idx] = merge(ref_mem[idx], wd, st);
                chk("rnd_wr_err", 32'(err), 0);
                chk("rnd_wr_lat", 32'(lat), 2);
            end else if (op == 2) begin
                idx = $urandom_range(0, FBW - 1);
                apb(1'b0, 32'(idx) << 2, 32'h0, 4'h0, rd, err, lat, nm);
                chk("rnd_rd_data", rd, ref_mem[idx]);
                chk("rnd_rd_lat", 32'(lat), 3);
            end else begin
                idx = $urandom_range(FBW, (1 << AW) - 1);
                apb(1'(t & 1), 32'(idx) << 2, $urandom, 4'hF, rd, err, lat, nm);
                chk("rnd_oor_err", 32'(err), 1);
                chk("rnd_oor_no_mem", 32'(nm), 0);
            end
        end

        // Asynchronous reset in the middle of a read.
        apb(1'b1, 32'd9 << 2, 32'hDEADBEEF, 4'hF, rd, err, lat, nm);
        ref_mem[9] = 32'hDEADBEEF;
        apb(1'b0, 32'd9 << 2, 32'h0, 4'h0, rd, err, lat, nm);
        chk("pre_reset_rd", rd, 32'hDEADBEEF);
        in_paddr = 32'd9 << 2; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
        tick();
        in_penable = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_prdata", in_prdata, 0);
        chk("mid_rst_pready", 32'(in_pready), 0);
        chk("mid_rst_mem_en", 32'(mem_en), 0);
        in_psel = 1'b0; in_penable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        apb(1'b0, 32'd9 << 2, 32'h0, 4'h0, rd, err, lat, nm);
        chk("post_reset_rd", rd, ref_mem[9]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
